retire_trace_buffer: RTL and testbench

- Synthesizable in-design retirement monitor. Taps the writeback/memory stage of the 5-stage pipeline. Gives each retired event a 0-based instruction number, buffers trace records in a FIFO for valid/ready readout (debug UART or sim dumper), and keeps cycle and instruction counters.
- Detects halt, then drains. Detects runaway execution with a watchdog. Records dropped on overflow are counted, never silently lost.

---
 rtl/trace_pkg.sv | 36 +++
 rtl/retire_trace_buffer_if.sv | 38 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/retire_trace_buffer.sv | 128 ++++++++++++
 tb/tb_retire_trace_buffer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the retirement trace monitor.
// Holds the event-kind codes, the monitor state encoding and the packed trace record
// that is carried through the FIFO. Record field widths are fixed here; the top checks
// at elaboration that its width parameters agree with them.
package trace_pkg;

    localparam int unsigned TRACE_DATA_W = 16;
    localparam int unsigned TRACE_PC_W   = 16;
    localparam int unsigned TRACE_REG_W  = 4;
    localparam int unsigned TRACE_CNT_W  = 32;

    localparam logic [1:0] KIND_NOP  = 2'd0;
    localparam logic [1:0] KIND_REG  = 2'd1;
    localparam logic [1:0] KIND_MEM  = 2'd2;
    localparam logic [1:0] KIND_HALT = 2'd3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        TOUT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [TRACE_CNT_W-1:0]  inum;
        logic [1:0]              kind;
        logic                    load;
        logic [TRACE_PC_W-1:0]   pc;
        logic [TRACE_REG_W-1:0]  regId;
        logic [TRACE_DATA_W-1:0] data;
        logic [TRACE_DATA_W-1:0] addr;
    } trace_rec_t;

    localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Event-in / record-out bundle of the retirement trace monitor.
// master: pipeline tap and trace consumer side (drives ev_*, out_ready).
// slave : the monitor (drives out_valid and the out_* record fields).
interface retire_trace_buffer_if import trace_pkg::*; #(
    parameter int unsigned DATA_W = TRACE_DATA_W,
    parameter int unsigned PC_W   = TRACE_PC_W,
    parameter int unsigned REG_W  = TRACE_REG_W,
    parameter int unsigned CNT_W  = TRACE_CNT_W
);
    logic              ev_valid;
    logic [1:0]        ev_kind;
    logic              ev_load;
    logic [PC_W-1:0]   ev_pc;
    logic [REG_W-1:0]  ev_reg;
    logic [DATA_W-1:0] ev_data;
    logic [DATA_W-1:0] ev_addr;

    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_inum;
    logic [1:0]        out_kind;
    logic              out_load;
    logic [PC_W-1:0]   out_pc;
    logic [REG_W-1:0]  out_reg;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] out_addr;

    modport master (
        output ev_valid, ev_kind, ev_load, ev_pc, ev_reg, ev_data, ev_addr, out_ready,
        input  out_valid, out_inum, out_kind, out_load, out_pc, out_reg, out_data, out_addr
    );

    modport slave (
        input  ev_valid, ev_kind, ev_load, ev_pc, ev_reg, ev_data, ev_addr, out_ready,
        output out_valid, out_inum, out_kind, out_load, out_pc, out_reg, out_data, out_addr
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head output.
// Ports: clk, rst_n (sync, active low); wrEn/wrData write request, wrAccept says the
// write is taken this cycle; rdValid/rdData registered head, rdReady pops it;
// level = entries held, including the one shown on rdData.
// A write while full is accepted when the head is popped in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    output logic             wrAccept,
    input  logic             rdReady,
    output logic             rdValid,
    output logic [WIDTH-1:0] rdData,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtrQ, rdPtrQ, rdPtrD;
    logic [LW-1:0]    levelQ, levelD, levelKept;
    logic             rdValidQ, rdValidD;
    logic [WIDTH-1:0] rdDataQ, rdDataD;
    logic             pop, push;

    always_comb begin
        pop       = rdValidQ & rdReady;
        wrAccept  = (levelQ != LW'(DEPTH)) | pop;
        push      = wrEn & wrAccept;
        rdPtrD    = rdPtrQ + AW'(pop);
        levelKept = levelQ - LW'(pop);
        levelD    = levelKept + LW'(push);
        // Only entries already stored before this edge can become the new head, so a
        // record appears one cycle after it was written.
        rdValidD  = (levelKept != '0);
        rdDataD   = rdValidD ? mem[rdPtrD] : rdDataQ;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtrQ] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtrQ   <= '0;
            rdPtrQ   <= '0;
            levelQ   <= '0;
            rdValidQ <= 1'b0;
            rdDataQ  <= '0;
        end else begin
            wrPtrQ   <= wrPtrQ + AW'(push);
            rdPtrQ   <= rdPtrD;
            levelQ   <= levelD;
            rdValidQ <= rdValidD;
            rdDataQ  <= rdDataD;
        end
    end

    assign rdValid = rdValidQ;
    assign rdData  = rdDataQ;
    assign level   = levelQ;

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace monitor for the writeback/memory stage.
// Ports: clk, rst_n (sync, active low), en (monitor enable); bus carries retire events
// in and trace records out (valid/ready); level = FIFO occupancy; cycle_count,
// inst_count, drop_count counters; overflow (sticky drop), halted (halt seen and
// drained), timeout (sticky watchdog).
module retire_trace_buffer import trace_pkg::*; #(
    parameter int unsigned DATA_W  = TRACE_DATA_W,
    parameter int unsigned PC_W    = TRACE_PC_W,
    parameter int unsigned REG_W   = TRACE_REG_W,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = TRACE_CNT_W,
    parameter int unsigned TIMEOUT = 100000,
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    retire_trace_buffer_if.slave  bus,
    output logic [LVL_W-1:0]      level,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      inst_count,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  overflow,
    output logic                  halted,
    output logic                  timeout
);
    // The record layout is fixed by the package widths.
    if (DATA_W != TRACE_DATA_W || PC_W != TRACE_PC_W || REG_W != TRACE_REG_W ||
        CNT_W != TRACE_CNT_W) begin : gWidthCheck
        $error("retire_trace_buffer: width parameters must match trace_pkg");
    end

    localparam logic [CNT_W-1:0] TOUT_AT = CNT_W'(TIMEOUT - 1);

    state_t                   stateQ, stateD;
    logic [CNT_W-1:0]         cycleQ, instQ, dropQ;
    logic                     overflowQ;
    logic                     counting, seen, atLimit, accept;
    trace_rec_t               rec, head;
    logic [TRACE_REC_W-1:0]   headBits;

    always_comb begin
        counting = en & ((stateQ == RUN) | (stateQ == DRAIN));
        seen     = bus.ev_valid & en & (stateQ == RUN);
        atLimit  = counting & (cycleQ == TOUT_AT);
        rec      = '{inum:  instQ,
                     kind:  bus.ev_kind,
                     load:  bus.ev_load,
                     pc:    bus.ev_pc,
                     regId: bus.ev_reg,
                     data:  bus.ev_data,
                     addr:  bus.ev_addr};

        stateD = stateQ;
        case (stateQ)
            RUN: begin
                // Watchdog wins over a halt in the same cycle; a dropped halt still halts.
                if (atLimit) begin
                    stateD = TOUT;
                end else if (seen && bus.ev_kind == KIND_HALT) begin
                    stateD = DRAIN;
                end
            end
            DRAIN: begin
                if (atLimit) begin
                    stateD = TOUT;
                end else if (level == '0) begin
                    stateD = DONE;
                end
            end
            default: ;  // DONE and TOUT hold until reset
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ    <= RUN;
            cycleQ    <= '0;
            instQ     <= '0;
            dropQ     <= '0;
            overflowQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (counting && cycleQ != '1) begin
                cycleQ <= cycleQ + CNT_W'(1);
            end
            if (seen) begin
                instQ <= instQ + CNT_W'(1);
            end
            if (seen && !accept) begin
                dropQ     <= dropQ + CNT_W'(1);
                overflowQ <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (TRACE_REC_W),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrEn     (seen),
        .wrData   (rec),
        .wrAccept (accept),
        .rdReady  (bus.out_ready),
        .rdValid  (bus.out_valid),
        .rdData   (headBits),
        .level    (level)
    );

    assign head         = trace_rec_t'(headBits);
    assign bus.out_inum = head.inum;
    assign bus.out_kind = head.kind;
    assign bus.out_load = head.load;
    assign bus.out_pc   = head.pc;
    assign bus.out_reg  = head.regId;
    assign bus.out_data = head.data;
    assign bus.out_addr = head.addr;

    assign cycle_count = cycleQ;
    assign inst_count  = instQ;
    assign drop_count  = dropQ;
    assign overflow    = overflowQ;
    assign halted      = (stateQ == DONE);
    assign timeout     = (stateQ == TOUT);

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer: directed scenarios with literal
// expectations plus randomized bursts, all compared every cycle against a queue model.
module tb_retire_trace_buffer;
    import trace_pkg::*;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [4:0]  level;
    logic [31:0] cycle_count, inst_count, drop_count;
    logic        overflow, halted, timeout;

    always #5 clk = ~clk;

    retire_trace_buffer_if #(.DATA_W(16), .PC_W(16), .REG_W(4), .CNT_W(32)) bus ();

    retire_trace_buffer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .bus         (bus),
        .level       (level),
        .cycle_count (cycle_count),
        .inst_count  (inst_count),
        .drop_count  (drop_count),
        .overflow    (overflow),
        .halted      (halted),
        .timeout     (timeout)
    );

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            nFail++;
            if (nFail <= 40) begin
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned stamp;   // edge number at which the record was stored
        logic [31:0] inum;
        logic [1:0]  kind;
        logic        load;
        logic [15:0] pc;
        logic [3:0]  rg;
        logic [15:0] data;
        logic [15:0] addr;
    } mrec_t;

    mrec_t       mq[$];
    int unsigned edgeNo = 0;
    logic [31:0] mCycle, mInst, mDrop;
    bit          mOvf, mDrain, mDone, mTout;
    bit          armed = 1'b0;
    bit          mPop, mSeen, mLive, mLim;
    int          mPre;
    mrec_t       mNew;

    // Head is visible once at least one further edge has passed since it was stored.
    function automatic bit mValid();
        return (mq.size() > 0) && (mq[0].stamp < edgeNo);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mCycle = 0; mInst = 0; mDrop = 0;
            mOvf = 0; mDrain = 0; mDone = 0; mTout = 0;
            armed = 1'b1;
        end else if (armed) begin
            mLive = !mDone && !mTout;
            mPop  = mValid() && bus.out_ready;
            mSeen = bus.ev_valid && en && mLive && !mDrain;
            mLim  = en && mLive && (mCycle == TIMEOUT - 1);
            mPre  = mq.size();
            if (mPop) void'(mq.pop_front());
            if (mSeen) begin
                if (mq.size() < DEPTH) begin
                    mNew.stamp = edgeNo + 1;
                    mNew.inum  = mInst;
                    mNew.kind  = bus.ev_kind;
                    mNew.load  = bus.ev_load;
                    mNew.pc    = bus.ev_pc;
                    mNew.rg    = bus.ev_reg;
                    mNew.data  = bus.ev_data;
                    mNew.addr  = bus.ev_addr;
                    mq.push_back(mNew);
                end else begin
                    mDrop = mDrop + 1;
                    mOvf  = 1'b1;
                end
                mInst = mInst + 1;
            end
            if (mLim) mTout = 1'b1;
            else if (mDrain && mLive && mPre == 0) mDone = 1'b1;
            else if (mSeen && bus.ev_kind == 2'd3) mDrain = 1'b1;
            if (en && mLive && mCycle != 32'hFFFF_FFFF) mCycle = mCycle + 1;
        end
        edgeNo++;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("out_valid", bus.out_valid, mValid());
            if (mValid()) begin
                chk("out_inum", bus.out_inum, mq[0].inum);
                chk("out_kind", bus.out_kind, mq[0].kind);
                chk("out_load", bus.out_load, mq[0].load);
                chk("out_pc",   bus.out_pc,   mq[0].pc);
                chk("out_reg",  bus.out_reg,  mq[0].rg);
                chk("out_data", bus.out_data, mq[0].data);
                chk("out_addr", bus.out_addr, mq[0].addr);
            end
            chk("level",       level,       mq.size());
            chk("cycle_count", cycle_count, mCycle);
            chk("inst_count",  inst_count,  mInst);
            chk("drop_count",  drop_count,  mDrop);
            chk("overflow",    overflow,    mOvf);
            chk("halted",      halted,      mDone);
            chk("timeout",     timeout,     mTout);
        end
    end

    // Records actually handed to the consumer, for literal ordering checks.
    logic [31:0] popInum[$];
    logic [15:0] popPc[$];
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            popInum.push_back(bus.out_inum);
            popPc.push_back(bus.out_pc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ev_valid = 1'b0; bus.ev_kind = 2'd0; bus.ev_load = 1'b0;
        bus.ev_pc = '0; bus.ev_reg = '0; bus.ev_data = '0; bus.ev_addr = '0;
    endtask

    task automatic ev(input logic [1:0] k, input logic [15:0] pc, input logic [3:0] rg,
                      input logic [15:0] d, input logic [15:0] a);
        bus.ev_valid = 1'b1; bus.ev_kind = k; bus.ev_load = 1'b0;
        bus.ev_pc = pc; bus.ev_reg = rg; bus.ev_data = d; bus.ev_addr = a;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; bus.out_ready = 1'b0; idle();
        step(1);
        rst_n = 1'b1;
        popInum.delete();
        popPc.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; bus.out_ready = 1'b0; idle();
        step(1);

        // Three events, consumer always ready.
        do_reset();
        bus.out_ready = 1'b1;
        ev(KIND_REG, 16'h0000, 4'd3, 16'h0005, 16'h0000); step(1);
        chk("t1_latency_invisible", bus.out_valid, 1'b0);
        ev(KIND_MEM, 16'h0002, 4'd0, 16'h0005, 16'h0040); step(1);
        chk("t1_first_visible", bus.out_valid, 1'b1);
        chk("t1_first_inum", bus.out_inum, 32'd0);
        ev(KIND_NOP, 16'h0004, 4'd0, 16'h0000, 16'h0000); step(1);
        idle(); step(4);
        chk("t1_inst_count", inst_count, 32'd3);
        chk("t1_pop_count", popInum.size(), 3);
        for (int i = 0; i < 3 && i < popInum.size(); i++) begin
            chk("t1_inum_order", popInum[i], 32'(i));
            chk("t1_pc_order", popPc[i], 16'(2 * i));
        end

        // Overflow with a stalled consumer.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            ev(KIND_REG, 16'(2 * i), 4'(i), 16'(i), 16'h0000); step(1);
        end
        idle(); step(1);
        chk("t2_level", level, 5'd16);
        chk("t2_drop", drop_count, 32'd4);
        chk("t2_overflow", overflow, 1'b1);
        chk("t2_inst", inst_count, 32'd20);
        bus.out_ready = 1'b1; step(20);
        chk("t2_pop_count", popInum.size(), 16);
        for (int i = 0; i < 16 && i < popInum.size(); i++) begin
            chk("t2_inum_order", popInum[i], 32'(i));
        end

        // Halt then drain.
        do_reset();
        bus.out_ready = 1'b1;
        ev(KIND_REG, 16'h0006, 4'd1, 16'h0011, 16'h0000); step(1);
        ev(KIND_REG, 16'h0008, 4'd2, 16'h0022, 16'h0000); step(1);
        ev(KIND_HALT, 16'h000A, 4'd0, 16'h0000, 16'h0000); step(1);
        chk("t3_not_yet_halted", halted, 1'b0);
        ev(KIND_REG, 16'h000C, 4'd3, 16'h0033, 16'h0000); step(1);
        idle(); step(5);
        chk("t3_inst", inst_count, 32'd3);
        chk("t3_halted", halted, 1'b1);
        chk("t3_level", level, 5'd0);
        chk("t3_pop_count", popInum.size(), 3);
        if (popPc.size() == 3) chk("t3_halt_pc", popPc[2], 16'h000A);

        // Watchdog with records still buffered.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ev(KIND_MEM, 16'(4 * i), 4'd0, 16'(i), 16'(16 * i)); step(1);
        end
        idle();
        for (int i = 0; i < 80 && timeout !== 1'b1; i++) step(1);
        chk("t4_timeout", timeout, 1'b1);
        chk("t4_cycle_at_limit", cycle_count, 32'd50);
        ev(KIND_REG, 16'h0100, 4'd1, 16'h0001, 16'h0000); step(1);
        idle(); step(2);
        chk("t4_cycle_frozen", cycle_count, 32'd50);
        chk("t4_inst_frozen", inst_count, 32'd5);
        chk("t4_level_held", level, 5'd5);
        bus.out_ready = 1'b1; step(8);
        chk("t4_drained", level, 5'd0);
        chk("t4_pop_count", popInum.size(), 5);

        // Push into a full FIFO while the head is popped.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ev(KIND_REG, 16'(2 * i), 4'(i), 16'(i), 16'h0000); step(1);
        end
        chk("t5_full", level, 5'd16);
        bus.out_ready = 1'b1;
        ev(KIND_REG, 16'h0040, 4'd7, 16'h0077, 16'h0000); step(1);
        bus.out_ready = 1'b0; idle();
        chk("t5_level_kept", level, 5'd16);
        chk("t5_no_drop", drop_count, 32'd0);
        chk("t5_no_overflow", overflow, 1'b0);
        step(1);

        // Reset in the middle of a drain.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ev(KIND_REG, 16'(2 * i), 4'(i), 16'(i + 1), 16'h0000); step(1);
        end
        ev(KIND_HALT, 16'h0008, 4'd0, 16'h0000, 16'h0000); step(1);
        idle(); step(1);
        chk("t6_level_before", level, 5'd5);
        rst_n = 1'b0; step(1);
        chk("t6_valid", bus.out_valid, 1'b0);
        chk("t6_level", level, 5'd0);
        chk("t6_cycle", cycle_count, 32'd0);
        chk("t6_inst", inst_count, 32'd0);
        chk("t6_drop", drop_count, 32'd0);
        chk("t6_halted", halted, 1'b0);
        chk("t6_payload", {bus.out_inum, bus.out_pc, bus.out_data}, 64'd0);
        rst_n = 1'b1;
        ev(KIND_REG, 16'h0002, 4'd1, 16'h0001, 16'h0000); step(1);
        idle();
        chk("t6_running_again", inst_count, 32'd1);
        step(2);

        // Randomized bursts; consumer readiness varies per burst.
        for (int b = 0; b < 16; b++) begin
            do_reset();
            for (int c = 0; c < 70; c++) begin
                en            = ($urandom_range(0, 9) != 0);
                bus.ev_valid  = 1'($urandom_range(0, 1));
                bus.ev_kind   = ($urandom_range(0, 39) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                bus.ev_load   = 1'($urandom_range(0, 1));
                bus.ev_pc     = 16'($urandom);
                bus.ev_reg    = 4'($urandom);
                bus.ev_data   = 16'($urandom);
                bus.ev_addr   = 16'($urandom);
                bus.out_ready = ($urandom_range(0, 3) < (b % 4)) || (b % 4 == 3);
                step(1);
            end
            idle();
            bus.out_ready = 1'b1;
            step(20);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
